// File: rtl/shift_unit_if.sv
// shift_unit_if: bundles the shifter's request/operand, bus-enable and
// status/result signals so the unit can be dropped between the ALU and the
// internal bus as one connection.
//   start  request, accepted only while the unit is idle
//   mode   operation select (PASS/ROL/ROR/RCL/RCR/SHL/SHR/SAR)
//   amt    shift amount, CNT_W bits
//   a      operand, WIDTH bits
//   cin    carry in for the rotate-through-carry modes
//   oe     bus output enable for w
//   w      result / working register, high impedance when oe=0
//   cf     carry flag
//   busy   unit is not idle
//   done   one-cycle pulse when w and cf are final
// master: the requester (drives operands, samples results).
// slave:  the shifter itself.
interface shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] a;
  logic             cin;
  logic             oe;
  logic [WIDTH-1:0] w;
  logic             cf;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amt, a, cin, oe,
    input  w, cf, busy, done
  );

  modport slave (
    input  start, mode, amt, a, cin, oe,
    output w, cf, busy, done
  );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: sequential shifter for the model-machine datapath.
// Executes a multi-bit shift/rotate one bit per clock with a start/done
// handshake and drives the internal bus only when output-enabled.
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  synchronous, active-high reset (aborts any operation in flight)
//   bus  shift_unit_if slave modport:
//          start/mode/amt/a/cin sampled on an accepted start,
//          oe gates w onto the bus (purely combinational),
//          w result, cf carry flag, busy, done pulse.
// Latency: amt+1 cycles from the accepting edge to the done cycle; PASS or
// amt=0 completes in one cycle.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  shift_unit_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_PASS = 3'b000,
    MODE_ROL  = 3'b001,
    MODE_ROR  = 3'b010,
    MODE_RCL  = 3'b011,
    MODE_RCR  = 3'b100,
    MODE_SHL  = 3'b101,
    MODE_SHR  = 3'b110,
    MODE_SAR  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             cf_q,    cf_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  mode_e            req_mode;
  logic             req_uses_cin;
  logic             req_no_shift;

  logic [WIDTH-1:0] step_r;
  logic             step_cf;

  assign req_mode     = mode_e'(bus.mode);
  assign req_uses_cin = (req_mode == MODE_RCL) || (req_mode == MODE_RCR);
  // PASS ignores amt, so it completes exactly like a zero-length shift.
  assign req_no_shift = (req_mode == MODE_PASS) || (bus.amt == '0);

  // One single-bit step of the latched operation; cf takes the bit that
  // leaves the register.
  always_comb begin
    step_r  = r_q;
    step_cf = cf_q;
    case (mode_q)
      MODE_ROL: begin
        step_r  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        step_cf = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        step_r  = {r_q[0], r_q[WIDTH-1:1]};
        step_cf = r_q[0];
      end
      MODE_RCL: begin
        step_r  = {r_q[WIDTH-2:0], cf_q};
        step_cf = r_q[WIDTH-1];
      end
      MODE_RCR: begin
        step_r  = {cf_q, r_q[WIDTH-1:1]};
        step_cf = r_q[0];
      end
      MODE_SHL: begin
        step_r  = {r_q[WIDTH-2:0], 1'b0};
        step_cf = r_q[WIDTH-1];
      end
      MODE_SHR: begin
        step_r  = {1'b0, r_q[WIDTH-1:1]};
        step_cf = r_q[0];
      end
      MODE_SAR: begin
        step_r  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        step_cf = r_q[0];
      end
      default: begin
        step_r  = r_q;
        step_cf = cf_q;
      end
    endcase
  end

  // Next-state logic. Register, cf and mode hold everywhere except on an
  // accepted start or a SHIFT step.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r_d     = r_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = bus.a;
          cnt_d   = bus.amt;
          mode_d  = req_mode;
          cf_d    = req_uses_cin ? bus.cin : 1'b0;
          state_d = req_no_shift ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        r_d   = step_r;
        cf_d  = step_cf;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_PASS;
      r_q     <= '0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.w    = bus.oe ? r_q : 'z;
  assign bus.cf   = cf_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus per DUT: index 0 is WIDTH=8/CNT_W=3, index 1 is WIDTH=16/CNT_W=4.
  logic        s_start [2];
  logic [2:0]  s_mode  [2];
  logic [15:0] s_amt   [2];
  logic [15:0] s_a     [2];
  logic        s_cin   [2];
  logic        s_oe    [2];

  logic [15:0] o_w    [2];
  logic        o_cf   [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        hz_ok  [2];

  shift_unit_if #(.WIDTH(8),  .CNT_W(3)) if0 ();
  shift_unit_if #(.WIDTH(16), .CNT_W(4)) if1 ();

  shift_unit #(.WIDTH(8),  .CNT_W(3)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  shift_unit #(.WIDTH(16), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.start = s_start[0];
  assign if0.mode  = s_mode[0];
  assign if0.amt   = s_amt[0][2:0];
  assign if0.a     = s_a[0][7:0];
  assign if0.cin   = s_cin[0];
  assign if0.oe    = s_oe[0];
  assign if1.start = s_start[1];
  assign if1.mode  = s_mode[1];
  assign if1.amt   = s_amt[1][3:0];
  assign if1.a     = s_a[1];
  assign if1.cin   = s_cin[1];
  assign if1.oe    = s_oe[1];

  assign o_w[0]    = {8'h00, if0.w};
  assign o_w[1]    = if1.w;
  assign o_cf[0]   = if0.cf;
  assign o_cf[1]   = if1.cf;
  assign o_busy[0] = if0.busy;
  assign o_busy[1] = if1.busy;
  assign o_done[0] = if0.done;
  assign o_done[1] = if1.done;
  // A 2-state simulator resolves an undriven bus to zero.
  assign hz_ok[0]  = (if0.w === {8{1'bz}})  || (if0.w === 8'h00);
  assign hz_ok[1]  = (if1.w === {16{1'bz}}) || (if1.w === 16'h0000);

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Final result of a whole operation, from the mode definitions as
  // arithmetic on the full value: rotates through carry are rotations of
  // the (W+1)-bit value {cin, a}. Returns {cf, result}.
  function automatic logic [16:0] expect_op(input int W, input logic [2:0] md, input int k,
                                            input logic [15:0] a, input logic ci);
    logic [31:0] mask, m1, v, r;
    logic        c;
    mask = (32'd1 << W) - 32'd1;
    v    = {16'd0, a} & mask;
    r    = v;
    c    = (md == 3'd3 || md == 3'd4) ? ci : 1'b0;
    if (md != 3'd0 && k != 0) begin
      case (md)
        3'd1: begin r = ((v << k) | (v >> (W - k))) & mask; c = r[0]; end
        3'd2: begin r = ((v >> k) | (v << (W - k))) & mask; c = r[W-1]; end
        3'd3: begin
          m1 = (32'd1 << (W + 1)) - 32'd1;
          v  = v | (32'(ci) << W);
          r  = ((v << k) | (v >> (W + 1 - k))) & m1;
          c  = r[W];
          r  = r & mask;
        end
        3'd4: begin
          m1 = (32'd1 << (W + 1)) - 32'd1;
          v  = v | (32'(ci) << W);
          r  = ((v >> k) | (v << (W + 1 - k))) & m1;
          c  = r[W];
          r  = r & mask;
        end
        3'd5: begin r = (v << k) & mask; c = v[W-k]; end
        3'd6: begin r = v >> k; c = v[k-1]; end
        default: begin
          r = v >> k;
          if (v[W-1]) r = r | (mask & ~(mask >> k));
          c = v[k-1];
        end
      endcase
    end
    return {c, r[15:0]};
  endfunction

  // Model: per DUT, whether an operation is in flight, how many cycles of it
  // remain (the last one is the done cycle), and the expected final values.
  bit          m_init = 1'b0;
  bit          m_active [2];
  int          m_rem    [2];
  logic [15:0] m_w      [2];
  logic        m_cf     [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] = 1'b0;
        m_rem[d]    = 0;
        m_w[d]      = 16'h0;
        m_cf[d]     = 1'b0;
      end else if (!m_active[d]) begin
        if (s_start[d]) begin
          int          k;
          logic [16:0] res;
          k   = (d == 1) ? int'(s_amt[1][3:0]) : int'(s_amt[0][2:0]);
          res = expect_op((d == 1) ? 16 : 8, s_mode[d], k, s_a[d], s_cin[d]);
          m_w[d]      = res[15:0];
          m_cf[d]     = res[16];
          m_rem[d]    = (s_mode[d] == 3'd0 || k == 0) ? 1 : k + 1;
          m_active[d] = 1'b1;
        end
      end else begin
        m_rem[d]--;
        if (m_rem[d] == 0) m_active[d] = 1'b0;
      end
    end
    if (rst) m_init = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, 32'(o_busy[d]), 32'(m_active[d]));
        chk("done", d, 32'(o_done[d]), 32'(m_active[d] && m_rem[d] == 1));
        if (!m_active[d] || m_rem[d] == 1) begin
          chk("cf", d, 32'(o_cf[d]), 32'(m_cf[d]));
          if (s_oe[d]) chk("w", d, 32'(o_w[d]), 32'(m_w[d]));
        end
        if (!s_oe[d]) chk("w_hiz", d, 32'(hz_ok[d]), 32'd1);
      end
    end
  end

  // Issue one operation, optionally poke a second start at wait-cycle
  // `poke`, and compare latency and final values against literals.
  task automatic run_op(input int d, input string nm, input logic [2:0] md, input int am,
                        input logic [15:0] av, input logic ci,
                        input logic [15:0] ew, input logic ecf, input int elat, input int poke);
    int n;
    bit seen;
    @(posedge clk); #1;
    s_start[d] = 1'b1; s_mode[d] = md; s_amt[d] = 16'(am); s_a[d] = av; s_cin[d] = ci;
    @(posedge clk); #1;
    // Operands move after acceptance and must not matter.
    s_a[d] = ~av; s_cin[d] = ~ci; s_mode[d] = ~md; s_amt[d] = 16'(am + 1);
    n = 1; seen = 1'b0;
    while (!seen && n < 40) begin
      if (o_done[d]) seen = 1'b1;
      else begin
        s_start[d] = (n == poke);
        if (n == poke) begin
          s_mode[d] = 3'b101; s_a[d] = 16'hFFFF; s_amt[d] = 16'd1; s_cin[d] = 1'b1;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    s_start[d] = 1'b0;
    if (!seen) $display("FAIL %s_timeout dut%0d: no done within 40 cycles", nm, d);
    chk({nm, "_lat"}, d, 32'(n), 32'(elat));
    chk({nm, "_w"},   d, 32'(o_w[d]), 32'(ew));
    chk({nm, "_cf"},  d, 32'(o_cf[d]), 32'(ecf));
  endtask

  initial begin
    int first, second;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_start[d] = 1'b0; s_mode[d] = 3'd0; s_amt[d] = 16'd0;
      s_a[d] = 16'h0; s_cin[d] = 1'b0; s_oe[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_w",    0, 32'(o_w[0]), 32'h0);
    chk("rst_cf",   0, 32'(o_cf[0]), 32'h0);
    chk("rst_busy", 0, 32'(o_busy[0]), 32'h0);
    chk("rst_done", 0, 32'(o_done[0]), 32'h0);
    s_oe[0] = 1'b0;
    #1 chk("rst_hiz", 0, 32'(hz_ok[0]), 32'd1);
    s_oe[0] = 1'b1;

    // WIDTH=8
    run_op(0, "rol",   3'd1, 1, 16'h81, 1'b0, 16'h03, 1'b1, 2, -1);
    s_oe[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("hold_hiz", 0, 32'(hz_ok[0]), 32'd1);
    chk("hold_cf", 0, 32'(o_cf[0]), 32'd1);
    s_oe[0] = 1'b1;
    #1 chk("hold_w", 0, 32'(o_w[0]), 32'h03);
    run_op(0, "ror",   3'd2, 3, 16'h01, 1'b0, 16'h20, 1'b0, 4, -1);
    run_op(0, "rcl",   3'd3, 2, 16'h80, 1'b0, 16'h01, 1'b0, 3, -1);
    run_op(0, "rcr",   3'd4, 1, 16'h01, 1'b1, 16'h80, 1'b1, 2, -1);
    run_op(0, "sar",   3'd7, 3, 16'h80, 1'b0, 16'hF0, 1'b0, 4, -1);
    run_op(0, "shr",   3'd6, 7, 16'h80, 1'b0, 16'h01, 1'b0, 8, -1);
    run_op(0, "shl",   3'd5, 1, 16'h81, 1'b0, 16'h02, 1'b1, 2, -1);
    run_op(0, "rol0",  3'd1, 0, 16'h5A, 1'b0, 16'h5A, 1'b0, 1, -1);
    run_op(0, "pass",  3'd0, 5, 16'h3C, 1'b1, 16'h3C, 1'b0, 1, -1);
    run_op(0, "rcr0",  3'd4, 0, 16'h33, 1'b1, 16'h33, 1'b1, 1, -1);
    run_op(0, "rcl7",  3'd3, 7, 16'h00, 1'b1, 16'h40, 1'b0, 8, -1);
    run_op(0, "sarp",  3'd7, 2, 16'h40, 1'b0, 16'h10, 1'b0, 3, -1);
    run_op(0, "busy_ign", 3'd2, 5, 16'h01, 1'b0, 16'h08, 1'b0, 6, 2);

    // start held high: second op accepted on the first idle cycle
    @(posedge clk); #1;
    s_start[0] = 1'b1; s_mode[0] = 3'd1; s_amt[0] = 16'd2; s_a[0] = 16'h01; s_cin[0] = 1'b0;
    first = -1; second = -1;
    for (int n = 0; n < 30 && second < 0; n++) begin
      @(posedge clk); #1;
      if (o_done[0]) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    s_start[0] = 1'b0;
    chk("b2b_period", 0, 32'(second - first), 32'd4);
    chk("b2b_w", 0, 32'(o_w[0]), 32'h04);
    for (int n = 0; n < 10 && o_busy[0]; n++) begin
      @(posedge clk); #1;
    end

    // reset in the middle of a shift
    @(posedge clk); #1;
    s_start[0] = 1'b1; s_mode[0] = 3'd5; s_amt[0] = 16'd7; s_a[0] = 16'hFF; s_cin[0] = 1'b0;
    @(posedge clk); #1;
    s_start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_w",    0, 32'(o_w[0]), 32'h0);
    chk("abort_cf",   0, 32'(o_cf[0]), 32'h0);
    chk("abort_busy", 0, 32'(o_busy[0]), 32'h0);
    for (int n = 0; n < 10; n++) begin
      chk("abort_done", 0, 32'(o_done[0]), 32'h0);
      @(posedge clk); #1;
    end

    // WIDTH=16, CNT_W=4
    run_op(1, "rol",   3'd1, 1,  16'h8001, 1'b0, 16'h0003, 1'b1, 2, -1);
    run_op(1, "ror",   3'd2, 3,  16'h0001, 1'b0, 16'h2000, 1'b0, 4, -1);
    run_op(1, "rcl",   3'd3, 2,  16'h8000, 1'b0, 16'h0001, 1'b0, 3, -1);
    run_op(1, "rcr",   3'd4, 1,  16'h0001, 1'b1, 16'h8000, 1'b1, 2, -1);
    run_op(1, "sar",   3'd7, 3,  16'h8000, 1'b0, 16'hF000, 1'b0, 4, -1);
    run_op(1, "shr",   3'd6, 15, 16'h8000, 1'b0, 16'h0001, 1'b0, 16, -1);
    run_op(1, "shl",   3'd5, 1,  16'h8001, 1'b0, 16'h0002, 1'b1, 2, -1);
    run_op(1, "rol0",  3'd1, 0,  16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 1, -1);
    run_op(1, "pass",  3'd0, 5,  16'h3C3C, 1'b0, 16'h3C3C, 1'b0, 1, -1);
    run_op(1, "rol15", 3'd1, 15, 16'h8001, 1'b0, 16'hC000, 1'b0, 16, -1);
    run_op(1, "busy_ign", 3'd6, 4, 16'h00F0, 1'b0, 16'h000F, 1'b0, 5, 2);
    s_oe[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("hold_hiz", 1, 32'(hz_ok[1]), 32'd1);
    s_oe[1] = 1'b1;

    repeat (3) @(posedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
